vga_scan_timing: RTL
====================

# vga_scan_timing

Raster timing generator and VGA output stage for the tile renderer. It produces the pixel coordinates `display_col` and `display_row` that drive the tile/sprite/palette pixel pipeline, then takes back the 24-bit `color` that pipeline returns. It delays its own sync and blanking signals by the pipeline latency so that the registered RGB, HSYNC and VSYNC leave the chip aligned on the same pixel. Default timing is 1280x1024@60 Hz (108 MHz pixel clock), which matches the 40x32 board of 32-pixel tiles.

## Interface
Parameters:
- `H_VISIBLE`, default 1280: active pixels per line.
- `H_FRONT`, default 48; `H_SYNC`, default 112; `H_BACK`, default 248: horizontal porches and sync width, in pixels.
- `V_VISIBLE`, default 1024: active lines per frame.
- `V_FRONT`, default 1; `V_SYNC`, default 3; `V_BACK`, default 38: vertical porches and sync width, in lines.
- `SYNC_POL`, default 1: asserted level of both sync outputs.
- `PIPE_DELAY`, default 5: cycles from a coordinate being presented to its `color` being valid at the input.

Ports:
- `clock`, input, 1: pixel clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `color`, input, 24: pixel colour from the pixel pipeline, {R[23:16], G[15:8], B[7:0]}.
- `display_col`, output, 12: horizontal counter, 0..H_TOTAL-1.
- `display_row`, output, 11: vertical counter, 0..V_TOTAL-1.
- `frame_start`, output, 1: one-cycle pulse while the counters are at (0,0).
- `vga_r`, `vga_g`, `vga_b`, output, 8 each: registered colour; zero while blanked.
- `vga_hs`, `vga_vs`, output, 1 each: aligned sync outputs.
- `vga_blank_n`, output, 1: high on active pixels at the output.

## Operation
- Totals:
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (default 1688).
  - V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (default 1066).
- Counters: `display_col` and `display_row` are register outputs.
  - The column increments every cycle.
  - When the column is H_TOTAL-1, it wraps to 0 and the row increments.
  - When the row is V_TOTAL-1 on that same edge, the row wraps to 0.
  - Coordinates are always emitted, including during blanking; downstream ignores blanked values.
- Raw signals, combinational from the counters:
  - active = (col < H_VISIBLE) && (row < V_VISIBLE).
  - hs_raw is asserted when H_VISIBLE+H_FRONT <= col < H_VISIBLE+H_FRONT+H_SYNC.
  - vs_raw is asserted when V_VISIBLE+V_FRONT <= row < V_VISIBLE+V_FRONT+V_SYNC.
  - vs_raw changes only at col = 0.
- Delay line: a PIPE_DELAY-stage shift register carries {active, hs_raw, vs_raw}.
- Output register, updated every edge from the last delay stage:
  - vga_blank_n <= active_d.
  - {vga_r, vga_g, vga_b} <= active_d ? color : 24'h0.
  - vga_hs <= hs_d ? SYNC_POL : ~SYNC_POL; vga_vs uses vs_d the same way.
- frame_start: registered, 1 in exactly the cycles where the counters read (0,0) following a wrap.
  - It is 0 in the first (0,0) cycle after reset release.
  - Default period is 1,799,408 cycles.
- Width rules:
  - Counters compare at full width; no truncation.
  - H_TOTAL must be at most 4096 and V_TOTAL at most 2048; this is checked at elaboration with an `initial` assertion.

## Timing
- Reset (reset = 0), applied immediately and asynchronously:
  - display_col = 0, display_row = 0, frame_start = 0.
  - All delay stages: inactive, syncs deasserted.
  - vga_r/g/b = 0, vga_blank_n = 0, vga_hs = vga_vs = ~SYNC_POL.
- After reset deasserts:
  - The coordinate (0,0) is presented until the first rising edge, which advances the column to 1.
  - The output stays blanked for PIPE_DELAY+1 edges.
- Latency:
  - The coordinate presented in cycle t has its `color` sampled at the end of cycle t+PIPE_DELAY.
  - vga_* reflect that pixel during cycle t+PIPE_DELAY+1.
  - HS, VS and blank_n carry identical latency, so their edges relative to RGB match the raw counter edges exactly.
- Boundaries:
  - Column wrap and row wrap on the same edge: the row goes to 0 and frame_start rises on that edge.
  - Reset mid-frame: all state clears at once; no partial line is completed; the delay line is flushed.
- No handshake: `color` must be valid every cycle exactly PIPE_DELAY cycles after its coordinate.

## Test plan
- Reset: hold reset low for 10 cycles with `color`=24'hFFFFFF → every output is at its reset value, and RGB stays 0 for the first 6 edges after release.
- Line timing: run 2 lines → the vga_hs asserted width is 112 cycles; it first asserts 1334 edges after reset release (col 1328 + 6); the period is 1688.
- Frame timing: run 2 frames → vga_vs is asserted for 3×1688 cycles starting at row 1025; frame_start pulses are 1,799,408 cycles apart; blank_n is high for 1280 cycles per visible line and low for rows 1024..1065.
- Alignment: model the pixel pipeline as a 5-stage delay with color = {row[7:0], 4'h0, col[11:0]} → the first active output pixel equals 24'h000000 (row 0, col 0); pixel (1279,1023) outputs 24'hFF04FF; the RGB pixel whose model value reads col 1280 or above is 0.
- Reset mid-line: assert reset at col 700 of row 500 → the outputs reach their reset values without waiting for a clock edge; after release the counters restart at (0,0); the first frame_start arrives 1,799,408 cycles later.
- Parameter override: set PIPE_DELAY=2 and H_VISIBLE=640 with other totals adjusted → the alignment and line-length checks hold with latency 3.

Source files
------------

// File: rtl/vga_scan_timing.sv
// Raster timing generator and registered VGA output stage. Coordinates go out to the
// pixel pipeline; sync/blank are delayed to meet the returning colour on the same pixel.
module vga_scan_timing #(
   parameter int   H_VISIBLE  = 1280,
   parameter int   H_FRONT    = 48,
   parameter int   H_SYNC     = 112,
   parameter int   H_BACK     = 248,
   parameter int   V_VISIBLE  = 1024,
   parameter int   V_FRONT    = 1,
   parameter int   V_SYNC     = 3,
   parameter int   V_BACK     = 38,
   parameter logic SYNC_POL   = 1'b1,
   parameter int   PIPE_DELAY = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [23:0] color,
   output logic [11:0] display_col,
   output logic [10:0] display_row,
   output logic        frame_start,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Comparisons run one bit wider than the counters so a limit of exactly 4096/2048 still fits.
   localparam logic [12:0] H_VIS_C  = 13'(H_VISIBLE);
   localparam logic [12:0] H_SS_C   = 13'(H_VISIBLE + H_FRONT);
   localparam logic [12:0] H_SE_C   = 13'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [12:0] H_LAST_C = 13'(H_TOTAL - 1);
   localparam logic [11:0] V_VIS_C  = 12'(V_VISIBLE);
   localparam logic [11:0] V_SS_C   = 12'(V_VISIBLE + V_FRONT);
   localparam logic [11:0] V_SE_C   = 12'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [11:0] V_LAST_C = 12'(V_TOTAL - 1);

   initial begin
      assert (H_TOTAL <= 4096 && V_TOTAL <= 2048 && PIPE_DELAY >= 1)
         else $fatal(1, "vga_scan_timing: totals exceed counter width or PIPE_DELAY < 1");
   end

   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } stage_t;

   logic [11:0] col_q, col_d;
   logic [10:0] row_q, row_d;
   logic        frame_start_q, frame_start_d;
   stage_t [PIPE_DELAY-1:0] pipe_q, pipe_d;
   logic [23:0] rgb_q, rgb_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        blank_n_q, blank_n_d;

   logic [12:0] col_ext;
   logic [11:0] row_ext;
   logic        line_end;
   stage_t      raw;
   stage_t      last;

   assign col_ext  = {1'b0, col_q};
   assign row_ext  = {1'b0, row_q};
   assign line_end = (col_ext == H_LAST_C);
   assign last     = pipe_q[PIPE_DELAY-1];

   always_comb begin
      raw        = '0;
      raw.active = (col_ext < H_VIS_C) && (row_ext < V_VIS_C);
      raw.hs     = (col_ext >= H_SS_C) && (col_ext < H_SE_C);
      raw.vs     = (row_ext >= V_SS_C) && (row_ext < V_SE_C);
   end

   always_comb begin
      col_d         = col_q + 12'd1;
      row_d         = row_q;
      frame_start_d = 1'b0;
      if (line_end) begin
         col_d = '0;
         if (row_ext == V_LAST_C) begin
            row_d         = '0;
            frame_start_d = 1'b1;
         end else begin
            row_d = row_q + 11'd1;
         end
      end
   end

   // Colour has no handshake: it must be valid exactly PIPE_DELAY cycles after its
   // coordinate, so the raw sync/blank bits ride a shift register of the same depth.
   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = raw;
      for (int i = 1; i < PIPE_DELAY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_comb begin
      blank_n_d = last.active;
      rgb_d     = last.active ? color : 24'h0;
      hs_d      = last.hs ? SYNC_POL : ~SYNC_POL;
      vs_d      = last.vs ? SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col_q         <= '0;
         row_q         <= '0;
         frame_start_q <= 1'b0;
         pipe_q        <= '0;
         rgb_q         <= '0;
         hs_q          <= ~SYNC_POL;
         vs_q          <= ~SYNC_POL;
         blank_n_q     <= 1'b0;
      end else begin
         col_q         <= col_d;
         row_q         <= row_d;
         frame_start_q <= frame_start_d;
         pipe_q        <= pipe_d;
         rgb_q         <= rgb_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_n_q     <= blank_n_d;
      end
   end

   assign display_col = col_q;
   assign display_row = row_q;
   assign frame_start = frame_start_q;
   assign vga_r       = rgb_q[23:16];
   assign vga_g       = rgb_q[15:8];
   assign vga_b       = rgb_q[7:0];
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank_n = blank_n_q;

endmodule
